vx_scoreboard_scalar: RTL
=========================

# vx_scoreboard_scalar

Per-issue-slot register scoreboard for the scalar pipeline. It sits directly downstream of the scalar instruction buffer, one instance per issue slot. It accepts one decoded instruction at a time into a single staging register and holds it until none of its source or destination registers has an outstanding write. It then issues the instruction to operand fetch and marks its destination pending until the matching writeback returns.

## Interface
Parameters:
- WIS_CNT, default 4: warps per issue slot; pending-table rows.
- NR_BITS, default 6: register index width; the table holds 2^NR_BITS bits per warp.
- DATAW, default 128: opaque instruction payload width, carried unmodified.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low.
- flush, in, 1: branch-mispredict flush for this slot.
- in_valid, in, 1: instruction from the ibuffer is valid.
- in_ready, out, 1: block can accept an instruction.
- in_wis, in, log2(WIS_CNT) (min 1): warp-in-slot index.
- in_wb, in, 1: instruction writes rd.
- in_rd / in_rs1 / in_rs2 / in_rs3, in, NR_BITS each: register indices.
- in_data, in, DATAW: payload.
- out_valid, out, 1: staged instruction is hazard-free.
- out_ready, in, 1: operand fetch accepts.
- out_wis, out_rd, out_wb, out_data: registered copies of the staged fields.
- wb_valid, in, 1: writeback event.
- wb_wis, in, log2(WIS_CNT); wb_rd, in, NR_BITS.
- wb_eop, in, 1: last packet of the writeback. Only packets with eop set clear pending.
- perf_stalls, out, 32: saturating count of hazard-stall cycles.

## Operation
- Staging register: stg_valid plus the captured fields. Capture happens on in_valid && in_ready.
- in_ready = !stg_valid || (out_valid && out_ready). One instruction can be accepted per cycle with back-to-back throughput. in_ready is 0 while reset is asserted.
- Hazard = pending[wis][rs1] | pending[wis][rs2] | pending[wis][rs3] | (stg_wb & pending[wis][rd]). This covers RAW and WAW.
- out_valid = stg_valid && !hazard.
- Issue = out_valid && out_ready. On issue, if stg_wb && stg_rd != 0, set pending[stg_wis][stg_rd].
- Register index 0 is never set pending and always reads as not pending.
- On wb_valid && wb_eop, clear pending[wb_wis][wb_rd].
- Set and clear on the same bit in the same cycle: the set wins. The bit stays 1.
- Set and clear on different bits in the same cycle: both apply.
- flush clears stg_valid on the next edge. A capture in the same cycle is dropped, so flush wins over capture.
- flush does not touch the pending table, because in-flight writebacks still return.
- perf_stalls increments on each cycle where stg_valid && hazard. It saturates at 0xFFFF_FFFF.
- A writeback to a non-pending bit is legal and has no effect.

## Timing
- Reset values: stg_valid=0, pending table all 0, out_valid=0, out_* fields 0, perf_stalls=0, in_ready=0 during reset.
- Minimum latency is 1 cycle from capture to out_valid. out_* outputs are driven from registers; only out_valid has a combinational term from the pending table.
- A writeback clear becomes visible to the hazard check the cycle after wb_valid. See Configuration for the bypass.
- A dependent instruction issued back-to-back after a producer stalls at least until that producer's writeback plus 1 cycle.
- out_valid must not drop without an issue, except on flush or reset. Payload is stable while out_valid && !out_ready.
- Reset asserted mid-operation: the staged instruction is discarded and all pending bits are cleared asynchronously.

## Configuration
- SCOREBOARD_BYPASS_EN defined: the hazard check uses pending with the same-cycle clear applied, i.e. pending & ~wb_clear_mask. A dependent instruction can then issue in the same cycle as its producer's writeback (eop).
- Not defined: no bypass. Hazard uses only the registered pending table, adding 1 cycle per dependency and giving a shorter critical path.
- Set-wins priority is identical in both modes.

## Test plan
- Reset then in_valid with wis=0, rd=5, wb=1 -> out_valid the next cycle. Issue sets pending[0][5]; perf_stalls stays 0.
- Producer rd=5 issued, then consumer rs1=5 staged -> out_valid=0 and perf_stalls counts. wb_valid/eop with wb_rd=5 -> out_valid 1 cycle later, or the same cycle with SCOREBOARD_BYPASS_EN.
- wb_valid with wb_eop=0 for rd=5 -> pending[0][5] stays set; the consumer keeps stalling until the eop packet.
- Consumer stalled, then flush=1 for one cycle -> stg_valid=0 and out_valid=0. A later writeback still clears rd=5.
- Instruction with rd=0 and wb=1 issued, then a consumer with rs1=0 -> no stall; the consumer issues 1 cycle after capture.
- Hold hazard for 10 cycles with out_ready=1 -> perf_stalls=10. Independent warps (wis=1) are not blocked by wis=0 pending bits.

Source files
------------

// File: rtl/vx_scoreboard_scalar.sv
// vx_scoreboard_scalar
//
// Per-issue-slot register scoreboard for the scalar pipeline. One decoded
// instruction is held in a staging register until none of its source
// registers (nor its destination, when it writes one) has an outstanding
// write. It is then issued to operand fetch and its destination is marked
// pending until the matching end-of-packet writeback returns.
//
// Optional feature (compile-time macro):
//   SCOREBOARD_BYPASS_EN - the hazard check sees a same-cycle writeback
//                          clear, so a dependent instruction can issue in
//                          the cycle its producer writes back. Without it
//                          only the registered pending table is consulted.
//
// Parameters:
//   WIS_CNT  warps per issue slot (pending-table rows)
//   NR_BITS  register index width (2^NR_BITS pending bits per warp)
//   DATAW    opaque payload width, carried unmodified
//
// Ports:
//   clk, reset (async, active-low), flush (drops the staged instruction)
//   in_*   instruction from the ibuffer (valid/ready handshake)
//   out_*  staged instruction towards operand fetch (valid/ready handshake)
//   wb_*   writeback events; only wb_eop packets clear pending bits
//   perf_stalls  saturating count of cycles spent stalled on a hazard

module vx_scoreboard_scalar #(
    parameter int WIS_CNT = 4,
    parameter int NR_BITS = 6,
    parameter int DATAW   = 128,
    localparam int WIS_W  = (WIS_CNT > 1) ? $clog2(WIS_CNT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIS_W-1:0]   in_wis,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [DATAW-1:0]   in_data,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIS_W-1:0]   out_wis,
    output logic [NR_BITS-1:0] out_rd,
    output logic               out_wb,
    output logic [DATAW-1:0]   out_data,

    input  logic               wb_valid,
    input  logic [WIS_W-1:0]   wb_wis,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,

    output logic [31:0]        perf_stalls
);

    localparam int NR_REGS = 1 << NR_BITS;

    // Staging register
    logic               stg_valid;
    logic [WIS_W-1:0]   stg_wis;
    logic               stg_wb;
    logic [NR_BITS-1:0] stg_rd;
    logic [NR_BITS-1:0] stg_rs1;
    logic [NR_BITS-1:0] stg_rs2;
    logic [NR_BITS-1:0] stg_rs3;
    logic [DATAW-1:0]   stg_data;

    // Pending table: one bit per (warp, register)
    logic [WIS_CNT-1:0][NR_REGS-1:0] pending;
    logic [WIS_CNT-1:0][NR_REGS-1:0] pending_next;

    logic [NR_REGS-1:0] pend_row;
    logic [NR_REGS-1:0] clr_row;
    logic [NR_REGS-1:0] eff_row;
    logic               hazard;
    logic               issue;
    logic               set_en;
    logic               wb_clr;
    logic [31:0]        stall_cnt;

    assign wb_clr = wb_valid && wb_eop;

    // Hazard check against the staged warp's row of the pending table
    always_comb begin
        pend_row = '0;
        for (int unsigned w = 0; w < WIS_CNT; w++) begin
            if (stg_wis == WIS_W'(w)) begin
                pend_row = pending[w];
            end
        end
`ifdef SCOREBOARD_BYPASS_EN
        clr_row = (wb_clr && (wb_wis == stg_wis)) ? (NR_REGS'(1) << wb_rd) : '0;
`else
        clr_row = '0;
`endif
        eff_row    = pend_row & ~clr_row;
        // x0 is hardwired: it never blocks anything
        eff_row[0] = 1'b0;
        hazard = eff_row[stg_rs1] | eff_row[stg_rs2] | eff_row[stg_rs3]
               | (stg_wb & eff_row[stg_rd]);
    end

    assign out_valid = stg_valid && !hazard;
    assign issue     = out_valid && out_ready;
    assign in_ready  = reset && (!stg_valid || issue);
    assign set_en    = issue && stg_wb && (stg_rd != '0);

    // Clear is applied first, then set, so a same-bit collision leaves the
    // bit set while independent bits each take their own update.
    always_comb begin
        pending_next = pending;
        for (int unsigned w = 0; w < WIS_CNT; w++) begin
            if (wb_clr && (wb_wis == WIS_W'(w))) begin
                pending_next[w][wb_rd] = 1'b0;
            end
        end
        for (int unsigned w = 0; w < WIS_CNT; w++) begin
            if (set_en && (stg_wis == WIS_W'(w))) begin
                pending_next[w][stg_rd] = 1'b1;
            end
            pending_next[w][0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_valid <= 1'b0;
            stg_wis   <= '0;
            stg_wb    <= 1'b0;
            stg_rd    <= '0;
            stg_rs1   <= '0;
            stg_rs2   <= '0;
            stg_rs3   <= '0;
            stg_data  <= '0;
            pending   <= '0;
            stall_cnt <= '0;
        end else begin
            // flush has priority over a same-cycle capture
            if (flush) begin
                stg_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                stg_valid <= 1'b1;
                stg_wis   <= in_wis;
                stg_wb    <= in_wb;
                stg_rd    <= in_rd;
                stg_rs1   <= in_rs1;
                stg_rs2   <= in_rs2;
                stg_rs3   <= in_rs3;
                stg_data  <= in_data;
            end else if (issue) begin
                stg_valid <= 1'b0;
            end

            pending <= pending_next;

            if (stg_valid && hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign out_wis     = stg_wis;
    assign out_rd      = stg_rd;
    assign out_wb      = stg_wb;
    assign out_data    = stg_data;
    assign perf_stalls = stall_cnt;

endmodule
